// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the CSR unit, including the performance counter bank types.
package core_config_pkg;

  localparam int XLEN         = 32;
  localparam int PERF_CNT_LEN = 64;
  localparam int PERF_N_CNT   = 4;
  localparam int PERF_N_EVT   = 16;
  localparam int PERF_EVT_W   = $clog2(PERF_N_EVT + 1);

  typedef enum logic [1:0] {
    SEL_LO   = 2'd0,
    SEL_HI   = 2'd1,
    SEL_EVT  = 2'd2,
    SEL_RSVD = 2'd3
  } perf_wr_sel_t;

  typedef logic [PERF_EVT_W-1:0] perf_evt_sel_t;

  // A single-channel bank still needs a 1-bit index field.
  function automatic int perf_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_bank_if.sv
// CSR write/read port of the performance counter bank; the CSR unit is master, the bank is slave.
interface perf_counter_bank_if
  import core_config_pkg::*;
#(
  parameter int IDX_W = perf_idx_w(PERF_N_CNT)
) ();

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  perf_wr_sel_t      wr_sel;
  logic [XLEN-1:0]   wr_data;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic              rd_hi;
  logic [XLEN-1:0]   rd_data;
  logic              rd_valid;

  modport master (
    output wr_en, wr_idx, wr_sel, wr_data, rd_en, rd_idx, rd_hi,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_idx, wr_sel, wr_data, rd_en, rd_idx, rd_hi,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/perf_counter_chan.sv
// One performance counter channel: event select, CSR write decode, increment and sticky overflow.
module perf_counter_chan
  import core_config_pkg::*;
#(
  parameter  int CNT_LEN = PERF_CNT_LEN,
  parameter  int N_EVT   = PERF_N_EVT,
  localparam int EVT_W   = $clog2(N_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               inhibit,
  input  logic [N_EVT-1:0]   events,
  input  logic               wr_hit,
  input  perf_wr_sel_t       wr_sel,
  input  logic [XLEN-1:0]    wr_data,
  output logic [CNT_LEN-1:0] cnt,
  output logic               ovf
);

  logic [EVT_W-1:0]   evt_sel;
  logic               evt_hit;
  logic               inc;
  logic [CNT_LEN-1:0] wr_lo_val;
  logic [CNT_LEN-1:0] wr_hi_val;

  // Select 0 and anything above N_EVT match no event bit, so the channel stays idle.
  always_comb begin
    evt_hit = 1'b0;
    for (int k = 0; k < N_EVT; k++) begin
      if (evt_sel == EVT_W'(k + 1)) evt_hit = events[k];
    end
  end

  assign inc = evt_hit && !inhibit;

  generate
    if (CNT_LEN > XLEN) begin : g_wide
      assign wr_lo_val = {cnt[CNT_LEN-1:XLEN], wr_data};
      assign wr_hi_val = {wr_data[CNT_LEN-XLEN-1:0], cnt[XLEN-1:0]};
    end else begin : g_narrow
      assign wr_lo_val = wr_data[CNT_LEN-1:0];
      assign wr_hi_val = cnt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      evt_sel <= '0;
      ovf     <= 1'b0;
    end else if (clk_en) begin
      if (wr_hit && (wr_sel != SEL_RSVD)) begin
        ovf <= 1'b0;
        case (wr_sel)
          SEL_LO:  cnt     <= wr_lo_val;
          SEL_HI:  cnt     <= wr_hi_val;
          default: evt_sel <= wr_data[EVT_W-1:0];
        endcase
      end else if (inc) begin
        cnt <= cnt + CNT_LEN'(1);
        if (&cnt) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of N_CNT performance counters with a registered CSR read mux and high-half shadow register.
// Define PERF_CNT_SNAPSHOT_EN to add the snap input and a snapshot bank that reads are served from.
module perf_counter_bank
  import core_config_pkg::*;
#(
  parameter  int N_CNT   = PERF_N_CNT,
  parameter  int CNT_LEN = PERF_CNT_LEN,
  parameter  int N_EVT   = PERF_N_EVT,
  localparam int IDX_W   = perf_idx_w(N_CNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [N_CNT-1:0] inhibit,
  input  logic [N_EVT-1:0] events,
`ifdef PERF_CNT_SNAPSHOT_EN
  input  logic             snap,
`endif
  perf_counter_bank_if.slave csr,
  output logic [N_CNT-1:0] ovf
);

  logic [CNT_LEN-1:0] cnt    [N_CNT];
  logic [CNT_LEN-1:0] rd_src [N_CNT];
  logic [CNT_LEN-1:0] rd_word;
  logic [XLEN-1:0]    rd_lo;
  logic [XLEN-1:0]    rd_hi_part;
  logic [XLEN-1:0]    shadow;
  logic [XLEN-1:0]    rd_data_q;
  logic               rd_valid_q;

  generate
    for (genvar i = 0; i < N_CNT; i++) begin : g_chan
      perf_counter_chan #(
        .CNT_LEN (CNT_LEN),
        .N_EVT   (N_EVT)
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .clk_en  (clk_en),
        .inhibit (inhibit[i]),
        .events  (events),
        .wr_hit  (csr.wr_en && (csr.wr_idx == IDX_W'(i))),
        .wr_sel  (csr.wr_sel),
        .wr_data (csr.wr_data),
        .cnt     (cnt[i]),
        .ovf     (ovf[i])
      );
    end
  endgenerate

`ifdef PERF_CNT_SNAPSHOT_EN
  logic [CNT_LEN-1:0] snap_bank [N_CNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CNT; i++) snap_bank[i] <= '0;
    end else if (clk_en && snap) begin
      for (int i = 0; i < N_CNT; i++) snap_bank[i] <= cnt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CNT; i++) rd_src[i] = snap_bank[i];
  end
`else
  always_comb begin
    for (int i = 0; i < N_CNT; i++) rd_src[i] = cnt[i];
  end
`endif

  // An index with no matching channel leaves the word at zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (csr.rd_idx == IDX_W'(i)) rd_word = rd_src[i];
    end
  end

  generate
    if (CNT_LEN > XLEN) begin : g_split_wide
      assign rd_lo      = rd_word[XLEN-1:0];
      assign rd_hi_part = XLEN'(rd_word[CNT_LEN-1:XLEN]);
    end else begin : g_split_narrow
      assign rd_lo      = XLEN'(rd_word);
      assign rd_hi_part = '0;
    end
  endgenerate

  // Low reads capture the high half into the shadow so a following high read is atomic.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      shadow     <= '0;
    end else if (clk_en) begin
      rd_valid_q <= csr.rd_en;
      if (csr.rd_en) begin
        if (csr.rd_hi) begin
          rd_data_q <= shadow;
        end else begin
          rd_data_q <= rd_lo;
          shadow    <= rd_hi_part;
        end
      end
    end
  end

  assign csr.rd_data  = rd_data_q;
  assign csr.rd_valid = rd_valid_q && clk_en;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: read expectations go to a scoreboard and are
// matched against rd_data when rd_valid is due.
module tb_perf_counter_bank;
  import core_config_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [3:0]  inhibit;
  logic [15:0] events;
`ifdef PERF_CNT_SNAPSHOT_EN
  logic        snap = 1'b0;
`endif
  logic [3:0]  ovf;

  int        cyc = 0;
  int        checks = 0;
  int        errors = 0;
  rd_exp_t   sb[$];
  rd_exp_t   mon_e;
  logic [19:0] pulse_pat;
  logic [19:0] inh_pat;

  perf_counter_bank_if #(.IDX_W(2)) csr_if ();

  perf_counter_bank dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .inhibit (inhibit),
    .events  (events),
`ifdef PERF_CNT_SNAPSHOT_EN
    .snap    (snap),
`endif
    .csr     (csr_if.slave),
    .ovf     (ovf)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    csr_if.wr_en = 1'b0;
    csr_if.rd_en = 1'b0;
  endtask

  task automatic set_write(input int idx, input perf_wr_sel_t sel, input logic [31:0] data);
    csr_if.wr_en   = 1'b1;
    csr_if.wr_idx  = 2'(idx);
    csr_if.wr_sel  = sel;
    csr_if.wr_data = data;
  endtask

  task automatic set_read(input int idx, input logic hi, input string tag, input logic [31:0] exp_data);
    rd_exp_t e;
    csr_if.rd_en  = 1'b1;
    csr_if.rd_idx = 2'(idx);
    csr_if.rd_hi  = hi;
    e.tag  = tag;
    e.data = exp_data;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  // Scoreboard side: each expected read must show up exactly one cycle after its request.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check_output({mon_e.tag, "_valid"}, 64'(csr_if.rd_valid), 64'd1);
        check_output(mon_e.tag, 64'(csr_if.rd_data), 64'(mon_e.data));
      end else if (csr_if.rd_valid) begin
        check_output("spurious_valid", 64'(csr_if.rd_valid), 64'd0);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    clk_en         = 1'b1;
    inhibit        = '0;
    events         = '1;
    csr_if.wr_en   = 1'b1;
    csr_if.wr_idx  = 2'd0;
    csr_if.wr_sel  = SEL_LO;
    csr_if.wr_data = 32'h0000_1234;
    csr_if.rd_en   = 1'b1;
    csr_if.rd_idx  = 2'd0;
    csr_if.rd_hi   = 1'b0;
    pulse_pat      = 20'h4924A;
    inh_pat        = 20'h08040;

    // Reset overrides pending writes, reads and events.
    repeat (3) next_cycle();
    check_output("rst_ovf", 64'(ovf), 64'd0);
    check_output("rst_rd_data", 64'(csr_if.rd_data), 64'd0);
    check_output("rst_rd_valid", 64'(csr_if.rd_valid), 64'd0);
    rst = 1'b0;
    idle_bus();
    repeat (100) next_cycle();
    events = '0;
    check_output("idle_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < 4; i++) begin
      set_read(i, 1'b0, "idle_lo", 32'd0);
      next_cycle();
      set_read(i, 1'b1, "idle_hi", 32'd0);
      next_cycle();
    end
    idle_bus();

    // Event counting on channel 0 with select truncated to 3.
    set_write(0, SEL_EVT, 32'hFFFF_FFE3);
    next_cycle();
    idle_bus();
    for (int c = 0; c < 20; c++) begin
      events  = pulse_pat[c] ? 16'h0004 : 16'h0000;
      inhibit = inh_pat[c] ? 4'b0001 : 4'b0000;
      next_cycle();
    end
    events  = '0;
    inhibit = '0;
    set_read(0, 1'b0, "cnt_lo", 32'd5);
    next_cycle();
    set_read(0, 1'b1, "cnt_hi", 32'd0);
    next_cycle();
    set_read(1, 1'b0, "other_ch", 32'd0);
    next_cycle();
    idle_bus();

    // Wrap-around and sticky overflow on channel 1.
    set_write(1, SEL_EVT, 32'd1);
    next_cycle();
    set_write(1, SEL_LO, 32'hFFFF_FFFF);
    next_cycle();
    set_write(1, SEL_HI, 32'hFFFF_FFFF);
    next_cycle();
    idle_bus();
    events = 16'h0001;
    next_cycle();
    events = '0;
    check_output("wrap_ovf_set", 64'(ovf), 64'h2);
    set_read(1, 1'b0, "wrap_lo", 32'd0);
    next_cycle();
    set_read(1, 1'b1, "wrap_hi", 32'd0);
    next_cycle();
    idle_bus();
    set_write(2, SEL_LO, 32'd0);
    next_cycle();
    idle_bus();
    check_output("ovf_other_wr", 64'(ovf), 64'h2);
    set_write(1, SEL_EVT, 32'd0);
    next_cycle();
    idle_bus();
    check_output("ovf_cleared", 64'(ovf), 64'd0);

    // Write beats increment on channel 2.
    set_write(2, SEL_EVT, 32'd1);
    next_cycle();
    idle_bus();
    events = 16'h0001;
    next_cycle();
    next_cycle();
    set_read(2, 1'b0, "run_cnt", 32'd2);
    next_cycle();
    idle_bus();
    set_write(2, SEL_LO, 32'h10);
    next_cycle();
    idle_bus();
    events = '0;
    set_read(2, 1'b0, "wr_prio", 32'h10);
    next_cycle();
    set_write(2, SEL_LO, 32'h55);
    set_read(2, 1'b0, "rd_pre_wr", 32'h10);
    next_cycle();
    idle_bus();
    set_read(2, 1'b0, "rd_post_wr", 32'h55);
    next_cycle();
    idle_bus();

    // Atomic 64-bit read across a carry on channel 3.
    set_write(3, SEL_EVT, 32'd2);
    next_cycle();
    set_write(3, SEL_LO, 32'hFFFF_FFFE);
    next_cycle();
    set_write(3, SEL_HI, 32'd0);
    next_cycle();
    idle_bus();
    events = 16'h0002;
    set_read(3, 1'b0, "atom_lo", 32'hFFFF_FFFE);
    next_cycle();
    idle_bus();
    next_cycle();
    set_read(3, 1'b1, "atom_hi", 32'd0);
    next_cycle();
    idle_bus();
    events = '0;
    set_read(3, 1'b0, "atom_lo2", 32'd1);
    next_cycle();
    set_read(3, 1'b1, "atom_hi2", 32'd1);
    next_cycle();
    idle_bus();
    repeat (2) next_cycle();

    // clk_en low freezes everything while writes, reads and events are active.
    clk_en = 1'b0;
    events = '1;
    for (int c = 0; c < 10; c++) begin
      set_write(c % 4, c[0] ? SEL_EVT : SEL_LO, 32'hDEAD_0000 | 32'(c));
      csr_if.rd_en  = 1'b1;
      csr_if.rd_idx = 2'(c);
      csr_if.rd_hi  = 1'b0;
      @(negedge clk);
      check_output("gate_valid", 64'(csr_if.rd_valid), 64'd0);
      next_cycle();
    end
    clk_en = 1'b1;
    events = '0;
    idle_bus();
    check_output("gate_rd_data", 64'(csr_if.rd_data), 64'd1);
    check_output("gate_ovf", 64'(ovf), 64'd0);
    set_read(0, 1'b0, "gate_c0", 32'd5);
    next_cycle();
    set_read(2, 1'b0, "gate_c2", 32'h55);
    next_cycle();
    set_read(3, 1'b0, "gate_c3lo", 32'd1);
    next_cycle();
    set_read(3, 1'b1, "gate_c3hi", 32'd1);
    next_cycle();
    idle_bus();
    events = '1;
    next_cycle();
    events = '0;
    set_read(0, 1'b0, "sel_keep0", 32'd6);
    next_cycle();
    set_read(1, 1'b0, "sel_keep1", 32'd0);
    next_cycle();
    set_read(2, 1'b0, "sel_keep2", 32'h56);
    next_cycle();
    set_read(3, 1'b0, "sel_keep3", 32'd2);
    next_cycle();
    idle_bus();

    for (int t = 0; t < 20 && sb.size() > 0; t++) next_cycle();
    check_output("sb_drain", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
